// File: rtl/cpu_step_controller.sv
// ---------------------------------------------------------------------------
// cpu_step_controller
//
// Turns a divided-clock level (tick_in) or a raw push-button (step_key) into
// single-cycle CPU clock-enable pulses on fast_clock. The processor can run
// free, run at tick rate, single-step on a key press, or halt. All logic sits
// on the one fast_clock domain.
//
// Optional feature macro: CPU_STEP_BURST_EN
//   undefined : in STEP mode each accepted key press gives one cpu_en pulse
//   defined   : each accepted key press gives BURST_LEN consecutive pulses
//
// Ports
//   fast_clock  in   1      system clock, all state on its rising edge
//   reset       in   1      synchronous, active-low reset
//   tick_in     in   1      divided-clock level, asynchronous to fast_clock
//   step_key    in   1      raw push-button, active-low (1 = released)
//   mode        in   2      00 HALT, 01 RUN, 10 SLOW (tick), 11 STEP (key)
//   cpu_en      out  1      CPU clock enable, one fast_clock wide per step
//   step_count  out  CNT_W  number of cycles with cpu_en=1, wraps
//   ledr        out  4      step_count[3:0]
//   halted      out  1      registered, 1 when mode was HALT last edge
// ---------------------------------------------------------------------------
module cpu_step_controller #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 32,
    parameter int BURST_LEN       = 4
) (
    input  logic             fast_clock,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             step_key,
    input  logic [1:0]       mode,
    output logic             cpu_en,
    output logic [CNT_W-1:0] step_count,
    output logic [3:0]       ledr,
    output logic             halted
);

    // Reject unusable configurations at elaboration time.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || BURST_LEN < 1 || CNT_W < 4) begin : g_bad_cfg
        $error("cpu_step_controller: unsupported parameter set");
    end

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_SLOW = 2'b10,
        MODE_STEP = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        K_IDLE,
        K_PRESS_DB,
        K_HELD,
        K_RELEASE_DB
    } key_state_e;

    mode_e w_mode;
    assign w_mode = mode_e'(mode);

    // ---------------- synchronizers ----------------
    logic [SYNC_STAGES-1:0] r_tick_sync;
    logic [SYNC_STAGES-1:0] r_key_sync;
    logic                   r_tick_prev;
    logic                   w_tick_rise;
    logic                   w_key;

    // Key chain resets to 1 so a held button after reset looks like a fresh press.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge fast_clock) begin
        if (!reset) begin
            r_tick_sync <= '0;
            r_tick_prev <= 1'b0;
            r_key_sync  <= '1;
        end else begin
            r_tick_sync <= {r_tick_sync[SYNC_STAGES-2:0], tick_in};
            r_tick_prev <= r_tick_sync[SYNC_STAGES-1];
            r_key_sync  <= {r_key_sync[SYNC_STAGES-2:0], step_key};
        end
    end

    assign w_tick_rise = r_tick_sync[SYNC_STAGES-1] & ~r_tick_prev;
    assign w_key       = r_key_sync[SYNC_STAGES-1];

    // ---------------- key debounce FSM ----------------
    key_state_e      r_key_state, w_key_state_nxt;
    logic [DB_W-1:0] r_db_cnt, w_db_cnt_nxt;
    logic            w_step_req;

    always_ff @(posedge fast_clock) begin
        if (!reset) begin
            r_key_state <= K_IDLE;
            r_db_cnt    <= '0;
        end else begin
            r_key_state <= w_key_state_nxt;
            r_db_cnt    <= w_db_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_key_state_nxt = r_key_state;
        w_db_cnt_nxt    = r_db_cnt;
        w_step_req      = 1'b0;
        case (r_key_state)
            K_IDLE: begin
                if (!w_key) begin
                    w_key_state_nxt = K_PRESS_DB;
                    w_db_cnt_nxt    = '0;
                end
            end
            K_PRESS_DB: begin
                if (w_key) begin
                    w_key_state_nxt = K_IDLE;
                end else if (r_db_cnt == DB_LAST) begin
                    // Single request per press: leaving for K_HELD makes it one cycle wide.
                    w_key_state_nxt = K_HELD;
                    w_step_req      = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            K_HELD: begin
                if (w_key) begin
                    w_key_state_nxt = K_RELEASE_DB;
                    w_db_cnt_nxt    = '0;
                end
            end
            K_RELEASE_DB: begin
                if (!w_key) begin
                    w_key_state_nxt = K_HELD;
                end else if (r_db_cnt == DB_LAST) begin
                    w_key_state_nxt = K_IDLE;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            default: w_key_state_nxt = K_IDLE;
        endcase
    end

    // ---------------- STEP-mode pulse source ----------------
    logic w_step_pulse;

`ifdef CPU_STEP_BURST_EN
    localparam int BST_W = $clog2(BURST_LEN + 1);

    // Holds the number of enables still owed after the current one.
    logic [BST_W-1:0] r_burst;

    always_ff @(posedge fast_clock) begin
        if (!reset || w_mode != MODE_STEP) begin
            r_burst <= '0;
        end else if (r_burst != '0) begin
            r_burst <= r_burst - BST_W'(1);
        end else if (w_step_req) begin
            r_burst <= BST_W'(BURST_LEN - 1);
        end
    end

    // A request arriving while a burst is running is absorbed by the first term.
    assign w_step_pulse = (r_burst != '0) | w_step_req;
`else
    assign w_step_pulse = w_step_req;
`endif

    // ---------------- enable, counter, status ----------------
    logic             r_cpu_en;
    logic             w_cpu_en_nxt;
    logic [CNT_W-1:0] r_step_count;
    logic             r_halted;

    // Requests seen in a mode that does not consume them are simply dropped here.
    always_comb begin
        w_cpu_en_nxt = 1'b0;
        case (w_mode)
            MODE_HALT: w_cpu_en_nxt = 1'b0;
            MODE_RUN:  w_cpu_en_nxt = 1'b1;
            MODE_SLOW: w_cpu_en_nxt = w_tick_rise;
            MODE_STEP: w_cpu_en_nxt = w_step_pulse;
            default:   w_cpu_en_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge fast_clock) begin
        if (!reset) begin
            r_cpu_en     <= 1'b0;
            r_step_count <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_cpu_en <= w_cpu_en_nxt;
            if (r_cpu_en) begin
                r_step_count <= r_step_count + CNT_W'(1);
            end
            r_halted <= (w_mode == MODE_HALT);
        end
    end

    assign cpu_en     = r_cpu_en;
    assign step_count = r_step_count;
    assign ledr       = r_step_count[3:0];
    assign halted     = r_halted;

endmodule
